// File: rtl/matrix_unorder_if.sv
// Bundles the matrix_unorder request (grid, shape, enable) and result signals.
// The master drives a run and the slave is the compactor.
interface matrix_unorder_if #(
  parameter int DATA_WIDTH = 9
);
  logic [2:0]               r;
  logic [2:0]               c;
  logic [25*DATA_WIDTH-1:0] grid_in;
  logic                     en;
  logic [25*DATA_WIDTH-1:0] data_out;
  logic [4:0]               elem_count;
  logic                     busy;
  logic                     isUnordered;

  modport master (
    output r, c, grid_in, en,
    input  data_out, elem_count, busy, isUnordered
  );

  modport slave (
    input  r, c, grid_in, en,
    output data_out, elem_count, busy, isUnordered
  );
endinterface

// File: rtl/matrix_unorder.sv
// Compacts the r x c matrix held in the top-left corner of a zero-padded 5x5
// grid into a dense element list, scanning one grid position per cycle.
module matrix_unorder #(
  parameter int DATA_WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  matrix_unorder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic [4:0]               pos_r;
  logic [4:0]               out_idx_r;
  logic [2:0]               r_l_r;
  logic [2:0]               c_l_r;
  logic [25*DATA_WIDTH-1:0] grid_l_r;
  logic [25*DATA_WIDTH-1:0] temp_r;
  logic [25*DATA_WIDTH-1:0] data_out_r;
  logic [4:0]               elem_count_r;
  logic                     busy_r;
  logic                     is_unordered_r;

  logic [2:0]               row_s;
  logic [2:0]               col_s;
  logic                     hit_s;
  logic [4:0]               idx_next_s;
  logic [25*DATA_WIDTH-1:0] temp_next_s;

  function automatic logic [2:0] clamp5(input logic [2:0] v);
    if (v > 3'd5) begin
      clamp5 = 3'd5;
    end else begin
      clamp5 = v;
    end
  endfunction

  // Next temp buffer and write index for the current scan position; the final
  // result takes temp_next_s so a write at position 24 is not lost.
  always_comb begin
    row_s       = 3'(pos_r / 5'd5);
    col_s       = 3'(pos_r % 5'd5);
    hit_s       = (row_s < r_l_r) && (col_s < c_l_r);
    temp_next_s = temp_r;
    idx_next_s  = out_idx_r;
    if (hit_s) begin
      temp_next_s[out_idx_r*DATA_WIDTH +: DATA_WIDTH] = grid_l_r[pos_r*DATA_WIDTH +: DATA_WIDTH];
      idx_next_s = out_idx_r + 5'd1;
    end else begin
      idx_next_s = out_idx_r;
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      pos_r          <= 5'd0;
      out_idx_r      <= 5'd0;
      r_l_r          <= 3'd0;
      c_l_r          <= 3'd0;
      grid_l_r       <= '0;
      temp_r         <= '0;
      data_out_r     <= '0;
      elem_count_r   <= 5'd0;
      busy_r         <= 1'b0;
      is_unordered_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.en) begin
            r_l_r     <= clamp5(bus.r);
            c_l_r     <= clamp5(bus.c);
            grid_l_r  <= bus.grid_in;
            temp_r    <= '0;
            pos_r     <= 5'd0;
            out_idx_r <= 5'd0;
            busy_r    <= 1'b1;
            state_r   <= SCAN;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (!bus.en) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            temp_r    <= temp_next_s;
            out_idx_r <= idx_next_s;
            pos_r     <= pos_r + 5'd1;
            if (pos_r == 5'd24) begin
              data_out_r     <= temp_next_s;
              elem_count_r   <= idx_next_s;
              busy_r         <= 1'b0;
              is_unordered_r <= 1'b1;
              state_r        <= DONE;
            end else begin
              state_r <= SCAN;
            end
          end
        end
        DONE: begin
          if (!bus.en) begin
            is_unordered_r <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          busy_r         <= 1'b0;
          is_unordered_r <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.elem_count  = elem_count_r;
  assign bus.busy        = busy_r;
  assign bus.isUnordered = is_unordered_r;

endmodule
